// File: rtl/imm_field_encoder_pkg.sv
// Shared widths, format encoding and range limits for the immediate/branch field encoder.
// The in_range helper is the single definition of what fits each format.
package imm_field_encoder_pkg;

    localparam int DATA_W  = 16;
    localparam int IMM_W   = 11;
    localparam int BR_W    = 13;
    localparam int FIELD_W = 13;

    typedef enum logic {
        FMT_IMM = 1'b0,
        FMT_BR  = 1'b1
    } fmt_e;

    localparam logic signed [DATA_W-1:0] IMM_MIN = -16'sd1024;
    localparam logic signed [DATA_W-1:0] IMM_MAX =  16'sd1023;
    localparam logic signed [DATA_W-1:0] BR_MIN  = -16'sd4096;
    localparam logic signed [DATA_W-1:0] BR_MAX  =  16'sd4095;

    function automatic logic in_range(input logic signed [DATA_W-1:0] v, input fmt_e fmt);
        if (fmt == FMT_BR)
            return (v >= BR_MIN) && (v <= BR_MAX);
        else
            return (v >= IMM_MIN) && (v <= IMM_MAX);
    endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Combinational narrowing of a 16-bit signed value into an 11-bit immediate or 13-bit branch field.
// Out-of-range values still produce the truncated field; fits reports representability.
module imm_fit_check
    import imm_field_encoder_pkg::*;
(
    input  logic [DATA_W-1:0]  value,
    input  logic               is_branch,
    output logic [FIELD_W-1:0] field,
    output logic               fits
);

    logic signed [DATA_W-1:0] value_s;
    fmt_e                     fmt;

    assign value_s = $signed(value);
    assign fmt     = fmt_e'(is_branch);

    always_comb begin
        field = '0;
        if (fmt == FMT_BR)
            field[BR_W-1:0] = value[BR_W-1:0];
        else
            field[IMM_W-1:0] = value[IMM_W-1:0];
        fits = in_range(value_s, fmt);
    end

endmodule

// File: rtl/imm_field_encoder.sv
// Valid/ready wrapper around imm_fit_check: one output register plus one skid entry,
// strict FIFO order, and a saturating out-of-range counter with a sticky error flag.
module imm_field_encoder
    import imm_field_encoder_pkg::*;
#(
    parameter int ERRCNT_W = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_value,
    input  logic                in_is_branch,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FIELD_W-1:0]  out_field,
    output logic                out_is_branch,
    output logic                out_fits,
    input  logic                err_clr,
    output logic [ERRCNT_W-1:0] err_count,
    output logic                err_sticky
);

    logic [FIELD_W-1:0] field_p0;
    logic               fits_p0;
    logic               acc_p0;

    logic               vld_p1;
    logic [FIELD_W-1:0] field_p1;
    logic               fits_p1;
    logic               br_p1;

    logic               skid_vld;
    logic [FIELD_W-1:0] skid_field;
    logic               skid_fits;
    logic               skid_br;

    logic [ERRCNT_W-1:0] err_cnt_q;
    logic                err_sticky_q;

    imm_fit_check u_fit (
        .value     (in_value),
        .is_branch (in_is_branch),
        .field     (field_p0),
        .fits      (fits_p0)
    );

    // in_ready comes straight from the skid flop, so it never depends on out_ready.
    assign in_ready = ~skid_vld;
    assign acc_p0   = in_valid & ~skid_vld;

    // ---- stage p0 -> p1: output register and skid entry
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p1     <= 1'b0;
            field_p1   <= '0;
            fits_p1    <= 1'b0;
            br_p1      <= 1'b0;
            skid_vld   <= 1'b0;
            skid_field <= '0;
            skid_fits  <= 1'b0;
            skid_br    <= 1'b0;
        end else begin
            if (!vld_p1 || out_ready) begin
                if (skid_vld) begin
                    vld_p1   <= 1'b1;
                    field_p1 <= skid_field;
                    fits_p1  <= skid_fits;
                    br_p1    <= skid_br;
                    skid_vld <= 1'b0;
                end else if (acc_p0) begin
                    vld_p1   <= 1'b1;
                    field_p1 <= field_p0;
                    fits_p1  <= fits_p0;
                    br_p1    <= in_is_branch;
                end else begin
                    vld_p1   <= 1'b0;
                end
            end else if (acc_p0) begin
                skid_vld   <= 1'b1;
                skid_field <= field_p0;
                skid_fits  <= fits_p0;
                skid_br    <= in_is_branch;
            end
        end
    end

    // A clear in the same cycle as a bad acceptance wins.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else if (err_clr) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else if (acc_p0 && !fits_p0) begin
            err_sticky_q <= 1'b1;
            if (err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign out_valid     = vld_p1;
    assign out_field     = field_p1;
    assign out_fits      = fits_p1;
    assign out_is_branch = br_p1;
    assign err_count     = err_cnt_q;
    assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_imm_field_encoder.sv
// Bench for imm_field_encoder: table vectors, backpressure/saturation/reset sequences and
// random traffic, all checked against a queue-based reference model.
module tb_imm_field_encoder;

    localparam int ERRCNT_W = 2;
    localparam int CNT_MAX  = 3;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_value = '0;
    logic        in_is_branch = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [12:0] out_field;
    logic        out_is_branch;
    logic        out_fits;
    logic        err_clr = 1'b0;
    logic [ERRCNT_W-1:0] err_count;
    logic        err_sticky;

    imm_field_encoder #(.ERRCNT_W(ERRCNT_W)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_value      (in_value),
        .in_is_branch  (in_is_branch),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_field     (out_field),
        .out_is_branch (out_is_branch),
        .out_fits      (out_fits),
        .err_clr       (err_clr),
        .err_count     (err_count),
        .err_sticky    (err_sticky)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] value;
        logic        br;
        logic [12:0] field;
        logic        fits;
    } item_t;

    item_t q[$];
    int    m_cnt = 0;
    logic  m_sticky = 1'b0;
    int    errors = 0;
    int    checks = 0;

    // Reference encoding from the numeric ranges and modular arithmetic.
    function automatic item_t ref_enc(input logic [15:0] v, input logic br);
        item_t r;
        int sv = $signed(v);
        int m  = br ? 8192 : 2048;
        int f  = ((sv % m) + m) % m;
        r.value = v;
        r.br    = br;
        r.fits  = (sv >= -(m / 2)) && (sv < (m / 2));
        r.field = 13'(f);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int se;
        int w;
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_field", 32'(out_field), 32'(q[0].field));
            check("out_fits", 32'(out_fits), 32'(q[0].fits));
            check("out_is_branch", 32'(out_is_branch), 32'(q[0].br));
            if (q[0].fits) begin
                w  = q[0].br ? 13 : 11;
                se = int'(out_field);
                if (se >= (1 << (w - 1))) se -= (1 << w);
                check("roundtrip", 32'(se), 32'(int'($signed(q[0].value))));
            end
        end
        check("err_count", 32'(err_count), 32'(m_cnt));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic cyc(input logic v, input logic [15:0] val, input logic br,
                       input logic ordy, input logic clr, output logic accepted);
        item_t it;
        logic  drain;
        in_valid = v; in_value = val; in_is_branch = br; out_ready = ordy; err_clr = clr;
        @(posedge CLK);
        accepted = v && (q.size() < 2);
        drain    = (q.size() > 0) && ordy;
        it       = ref_enc(val, br);
        if (drain) void'(q.pop_front());
        if (accepted) q.push_back(it);
        if (clr) begin
            m_cnt = 0; m_sticky = 1'b0;
        end else if (accepted && !it.fits) begin
            m_sticky = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        #1;
        check_all();
    endtask

    typedef struct {
        logic [15:0] value;
        logic        br;
        logic [12:0] field;
        logic        fits;
    } vec_t;

    vec_t vecs[7];
    logic acc;

    initial begin
        vecs[0] = '{16'hFFFC, 1'b0, 13'h07FC, 1'b1};
        vecs[1] = '{16'h0FFF, 1'b1, 13'h0FFF, 1'b1};
        vecs[2] = '{16'hF000, 1'b1, 13'h1000, 1'b1};
        vecs[3] = '{16'h1000, 1'b1, 13'h1000, 1'b0};
        vecs[4] = '{16'h03FF, 1'b0, 13'h03FF, 1'b1};
        vecs[5] = '{16'h0400, 1'b0, 13'h0400, 1'b0};
        vecs[6] = '{16'hFC00, 1'b0, 13'h0400, 1'b1};

        // Reset state
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_field", 32'(out_field), 32'd0);
        check("rst out_fits", 32'(out_fits), 32'd0);
        check("rst out_is_branch", 32'(out_is_branch), 32'd0);
        check("rst err_count", 32'(err_count), 32'd0);
        check("rst err_sticky", 32'(err_sticky), 32'd0);
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        #1 check_all();

        // Table vectors with the consumer always ready
        foreach (vecs[i]) begin
            cyc(1'b1, vecs[i].value, vecs[i].br, 1'b1, 1'b0, acc);
            check($sformatf("vec%0d field", i), 32'(out_field), 32'(vecs[i].field));
            check($sformatf("vec%0d fits", i), 32'(out_fits), 32'(vecs[i].fits));
            if (i == 3) check("vec3 err_count", 32'(err_count), 32'd1);
        end
        check("table err_count", 32'(err_count), 32'd2);
        check("table err_sticky", 32'(err_sticky), 32'd1);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, acc);

        // Backpressure: three back-to-back requests with the consumer stalled
        cyc(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, acc);
        cyc(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, acc);
        check("bp ready low", 32'(in_ready), 32'd0);
        cyc(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, acc);
        check("bp third refused", 32'(acc), 32'd0);
        check("bp hold", 32'(out_field), 32'h1);
        cyc(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, acc);
        check("bp hold2", 32'(out_field), 32'h1);
        cyc(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, acc);
        check("bp second out", 32'(out_field), 32'h2);
        cyc(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, acc);
        check("bp third accepted", 32'(acc), 32'd1);
        check("bp third out", 32'(out_field), 32'h3);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, acc);
        check("bp drained", 32'(out_valid), 32'd0);

        // Saturation at 3, then clear colliding with a bad request
        repeat (5) cyc(1'b1, 16'h0800, 1'b0, 1'b1, 1'b0, acc);
        check("sat count", 32'(err_count), 32'd3);
        cyc(1'b1, 16'h0800, 1'b0, 1'b1, 1'b1, acc);
        check("clr count", 32'(err_count), 32'd0);
        check("clr sticky", 32'(err_sticky), 32'd0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, acc);

        // Reset with output register and skid both full
        cyc(1'b1, 16'h2000, 1'b1, 1'b0, 1'b0, acc);
        cyc(1'b1, 16'h4000, 1'b0, 1'b0, 1'b0, acc);
        check("pre-rst ready", 32'(in_ready), 32'd0);
        RST_N = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst err_count", 32'(err_count), 32'd0);
        check("midrst err_sticky", 32'(err_sticky), 32'd0);
        q.delete(); m_cnt = 0; m_sticky = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        cyc(1'b1, 16'h0005, 1'b1, 1'b1, 1'b0, acc);
        check("post-rst field", 32'(out_field), 32'h5);
        check("post-rst fits", 32'(out_fits), 32'd1);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [15:0] v;
            case ($urandom_range(0, 3))
                0:       v = 16'($signed($urandom_range(0, 2100)) - 1050);
                1:       v = 16'($signed($urandom_range(0, 8400)) - 4200);
                default: v = 16'($urandom);
            endcase
            cyc(1'($urandom_range(0, 3) != 0), v, 1'($urandom), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 19) == 0), acc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
